// File: rtl/input_conditioner.sv
// Synchronizes and debounces three slide switches into X/Y/Z, with an optional
// {Z,Y,X} sweep mode built only when INPUT_CONDITIONER_SWEEP_EN is defined.
//
// state      | meaning
// DB_IDLE    | synchronized switch matches its stable value, counter at 0
// DB_COUNT   | switch differs from stable value, counting consecutive clocks
// MODE_SW    | outputs follow the debounced switches
// MODE_SWEEP | outputs follow the free-running 3-bit sweep code
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       sweep_en,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic       change_p
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {DB_IDLE, DB_COUNT} db_state_t;

    logic [2:0]    sw_sync1_q;
    logic [2:0]    sw_sync2_q;
    db_state_t     db_state_q [3];
    db_state_t     db_state_d [3];
    logic [CW-1:0] db_cnt_q [3];
    logic [CW-1:0] db_cnt_d [3];
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    out_q, out_d;
    logic          change_q, change_d;
    logic [2:0]    sel;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_state_d[i] = db_state_q[i];
            db_cnt_d[i]   = db_cnt_q[i];
            stable_d[i]   = stable_q[i];
            case (db_state_q[i])
                DB_IDLE: begin
                    if (sw_sync2_q[i] != stable_q[i]) begin
                        // A one-cycle debounce accepts the change on the first differing edge.
                        if (CW'(1) == CW'(DEBOUNCE_CYCLES)) begin
                            stable_d[i] = sw_sync2_q[i];
                        end else begin
                            db_state_d[i] = DB_COUNT;
                            db_cnt_d[i]   = CW'(1);
                        end
                    end
                end
                DB_COUNT: begin
                    if (sw_sync2_q[i] == stable_q[i]) begin
                        db_state_d[i] = DB_IDLE;
                        db_cnt_d[i]   = '0;
                    end else if (db_cnt_q[i] + CW'(1) == CW'(DEBOUNCE_CYCLES)) begin
                        stable_d[i]   = sw_sync2_q[i];
                        db_state_d[i] = DB_IDLE;
                        db_cnt_d[i]   = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    db_state_d[i] = DB_IDLE;
                    db_cnt_d[i]   = '0;
                end
            endcase
        end
    end

`ifdef INPUT_CONDITIONER_SWEEP_EN
    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic {MODE_SW, MODE_SWEEP} mode_t;

    // mode_q doubles as the second synchronizer stage of sweep_en, so the
    // mode flips on the same edge a two-flop synchronizer would deliver it.
    logic          sweep_sync1_q;
    mode_t         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    code_q, code_d;

    always_comb begin
        mode_d  = mode_q;
        presc_d = presc_q;
        code_d  = code_q;
        case (mode_q)
            MODE_SW: begin
                if (sweep_sync1_q) begin
                    mode_d  = MODE_SWEEP;
                    presc_d = '0;
                    code_d  = '0;
                end
            end
            MODE_SWEEP: begin
                if (!sweep_sync1_q) begin
                    mode_d = MODE_SW;
                end else if (presc_q == PW'(STEP_CYCLES - 1)) begin
                    presc_d = '0;
                    code_d  = code_q + 3'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: mode_d = MODE_SW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_sync1_q <= 1'b0;
            mode_q        <= MODE_SW;
            presc_q       <= '0;
            code_q        <= '0;
        end else begin
            sweep_sync1_q <= sweep_en;
            mode_q        <= mode_d;
            presc_q       <= presc_d;
            code_q        <= code_d;
        end
    end

    assign sel = (mode_d == MODE_SWEEP) ? code_d : stable_d;
`else
    logic unused_sweep_en;
    assign unused_sweep_en = sweep_en;
    assign sel             = stable_d;
`endif

    always_comb begin
        out_d    = sel;
        change_d = (sel != out_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            stable_q   <= '0;
            out_q      <= '0;
            change_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_state_q[i] <= DB_IDLE;
                db_cnt_q[i]   <= '0;
            end
        end else begin
            sw_sync1_q <= sw;
            sw_sync2_q <= sw_sync1_q;
            stable_q   <= stable_d;
            out_q      <= out_d;
            change_q   <= change_d;
            for (int i = 0; i < 3; i++) begin
                db_state_q[i] <= db_state_d[i];
                db_cnt_q[i]   <= db_cnt_d[i];
            end
        end
    end

    assign X        = out_q[0];
    assign Y        = out_q[1];
    assign Z        = out_q[2];
    assign change_p = change_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// switch activity against a sample-window reference model.
module tb_input_conditioner;
    localparam int D = 4;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = 3'b000;
    logic       sweep_en = 1'b0;
    logic       X, Y, Z, change_p;
    wire  [2:0] dut_out = {Z, Y, X};

    int checks = 0;
    int errors = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .sweep_en(sweep_en),
        .X(X), .Y(Y), .Z(Z), .change_p(change_p)
    );

    always #5 clk = ~clk;

    // Reference model: m_hist[k] is the raw switch word captured k+1 edges ago.
    // A channel flips when all D samples the debouncer judged disagree with it.
    logic [2:0] m_hist [$];
    logic       m_en_last;
    logic       m_sweep;
    int         m_cyc;
    logic [2:0] m_stable;
    logic [2:0] exp_out;
    logic       exp_chg;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < D + 2; i++) m_hist.push_back(3'b000);
        m_en_last = 1'b0;
        m_sweep   = 1'b0;
        m_cyc     = 0;
        m_stable  = 3'b000;
        exp_out   = 3'b000;
        exp_chg   = 1'b0;
    endtask

    task automatic tick();
        logic [2:0] sw_now;
        logic [2:0] nxt;
        logic [2:0] code;
        logic       en_now;
        logic       all_diff;
        sw_now = sw;
        en_now = sweep_en;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            nxt = m_stable;
            for (int c = 0; c < 3; c++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (m_hist[k][c] == m_stable[c]) all_diff = 1'b0;
                if (all_diff) nxt[c] = ~m_stable[c];
            end
            m_stable = nxt;
`ifdef INPUT_CONDITIONER_SWEEP_EN
            if (m_en_last && !m_sweep) m_cyc = 0;
            else if (m_en_last) m_cyc++;
            m_sweep   = m_en_last;
            m_en_last = en_now;
`else
            if (en_now === 1'bx) m_sweep = 1'b0;
`endif
            code    = 3'((m_cyc / S) % 8);
            exp_chg = ((m_sweep ? code : m_stable) != exp_out);
            exp_out = m_sweep ? code : m_stable;
            m_hist.push_front(sw_now);
            void'(m_hist.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 3'b111; sweep_en = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (dut_out !== 3'b000 || change_p !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold out=%b chg=%b want out=000 chg=0", dut_out, change_p);
            end
        end
        #2 rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (dut_out !== ((n >= 6) ? 3'b111 : 3'b000) || change_p !== (n == 6)) begin
                errors++;
                $display("FAIL reset_release edge=%0d out=%b chg=%b want out=%b chg=%b",
                         n, dut_out, change_p, (n >= 6) ? 3'b111 : 3'b000, n == 6);
            end
            checks++;
            if (dut_out !== exp_out || change_p !== exp_chg) begin
                errors++;
                $display("FAIL reset_model out=%b chg=%b want out=%b chg=%b", dut_out, change_p, exp_out, exp_chg);
            end
        end
    endtask

    task automatic test_clean_step();
        int pulses;
        sw = 3'b000;
        repeat (8) tick();
        sw = 3'b001;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            pulses += int'(change_p);
            checks++;
            if (dut_out !== ((n >= 6) ? 3'b001 : 3'b000) || dut_out !== exp_out || change_p !== exp_chg) begin
                errors++;
                $display("FAIL clean_step edge=%0d out=%b chg=%b want out=%b chg=%b", n, dut_out, change_p, exp_out, exp_chg);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL clean_step_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_glitch();
        sw = 3'b011;
        repeat (3) tick();
        sw = 3'b001;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (Y !== 1'b0 || change_p !== 1'b0 || dut_out !== exp_out) begin
                errors++;
                $display("FAIL glitch_reject edge=%0d Y=%b chg=%b out=%b want Y=0 chg=0 out=%b", n, Y, change_p, dut_out, exp_out);
            end
        end
        sw = 3'b011;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if (Y !== 1'b0 || dut_out !== exp_out) begin
                errors++;
                $display("FAIL glitch_long_hold edge=%0d Y=%b want 0", n, Y);
            end
        end
        sw = 3'b001;
        for (int m = 1; m <= 8; m++) begin
            tick();
            checks++;
            if (Y !== (m >= 1 && m < 6) || change_p !== (m == 1 || m == 6) || dut_out !== exp_out) begin
                errors++;
                $display("FAIL glitch_long_release edge=%0d Y=%b chg=%b want Y=%b chg=%b",
                         m, Y, change_p, (m >= 1 && m < 6), (m == 1 || m == 6));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        sw = 3'b110;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            pulses += int'(change_p);
            checks++;
            if (dut_out !== exp_out || change_p !== exp_chg) begin
                errors++;
                $display("FAIL back_to_back edge=%0d out=%b chg=%b want out=%b chg=%b", n, dut_out, change_p, exp_out, exp_chg);
            end
        end
        checks++;
        if (pulses !== 1 || dut_out !== 3'b110) begin
            errors++;
            $display("FAIL back_to_back_pulses pulses=%0d out=%b want pulses=1 out=110", pulses, dut_out);
        end
    endtask

`ifdef INPUT_CONDITIONER_SWEEP_EN
    task automatic test_sweep();
        logic [2:0] want;
        sw = 3'b101;
        repeat (8) tick();
        sweep_en = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            tick();
            want = (n < 2) ? 3'b101 : 3'((n - 2) / 3 % 8);
            checks++;
            if (dut_out !== want || change_p !== (n == 2 || (n > 2 && (n - 2) % 3 == 0)) ||
                dut_out !== exp_out || change_p !== exp_chg) begin
                errors++;
                $display("FAIL sweep edge=%0d out=%b chg=%b want out=%b chg=%b", n, dut_out, change_p, want, exp_chg);
            end
        end
        sweep_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (dut_out !== 3'b101 || dut_out !== exp_out) begin
            errors++;
            $display("FAIL sweep_leave out=%b want 101", dut_out);
        end
    endtask

    task automatic test_mode_exit();
        sw = 3'b011;
        repeat (8) tick();
        sweep_en = 1'b1;
        repeat (11) tick();
        checks++;
        if (dut_out !== 3'b011 || dut_out !== exp_out) begin
            errors++;
            $display("FAIL exit_setup_a out=%b want 011", dut_out);
        end
        sweep_en = 1'b0;
        for (int m = 1; m <= 6; m++) begin
            tick();
            checks++;
            if (dut_out !== 3'b011 || change_p !== 1'b0 || dut_out !== exp_out || change_p !== exp_chg) begin
                errors++;
                $display("FAIL exit_same edge=%0d out=%b chg=%b want out=011 chg=0", m, dut_out, change_p);
            end
        end
        sweep_en = 1'b1;
        repeat (14) tick();
        checks++;
        if (dut_out !== 3'b100 || dut_out !== exp_out) begin
            errors++;
            $display("FAIL exit_setup_b out=%b want 100", dut_out);
        end
        sweep_en = 1'b0;
        for (int m = 1; m <= 4; m++) begin
            tick();
            checks++;
            if (dut_out !== ((m >= 2) ? 3'b011 : 3'b100) || change_p !== (m == 2) ||
                dut_out !== exp_out || change_p !== exp_chg) begin
                errors++;
                $display("FAIL exit_diff edge=%0d out=%b chg=%b want out=%b chg=%b",
                         m, dut_out, change_p, (m >= 2) ? 3'b011 : 3'b100, m == 2);
            end
        end
    endtask
`else
    task automatic test_macro_off();
        sw = 3'b010;
        repeat (8) tick();
        for (int n = 1; n <= 30; n++) begin
            if ($urandom_range(0, 2) == 0) sweep_en = ~sweep_en;
            tick();
            checks++;
            if (dut_out !== 3'b010 || change_p !== 1'b0 || dut_out !== exp_out) begin
                errors++;
                $display("FAIL macro_off edge=%0d out=%b chg=%b want out=010 chg=0", n, dut_out, change_p);
            end
        end
        sweep_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) sw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) sweep_en = ~sweep_en;
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (dut_out !== 3'b000 || change_p !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset out=%b chg=%b want out=000 chg=0", dut_out, change_p);
                end
                tick();
                #1 rst_n = 1'b1;
                sweep_en = 1'b1;
            end
            tick();
            checks++;
            if (dut_out !== exp_out || change_p !== exp_chg) begin
                errors++;
                $display("FAIL random cycle=%0d out=%b chg=%b want out=%b chg=%b", i, dut_out, change_p, exp_out, exp_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_back_to_back();
`ifdef INPUT_CONDITIONER_SWEEP_EN
        test_sweep();
        test_mode_exit();
`else
        test_macro_off();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream stage feeding the 3-input combinational logic block (X, Y, Z -> F) on the lab board.
- Conditions three raw slide-switch inputs into clean, synchronous, debounced X/Y/Z levels.
- Also offers an on-chip sweep mode that walks {Z,Y,X} through 000..111 for hands-free truth-table checking. In that mode X toggles fastest, then Y, then Z.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clocks a synchronized input must differ from its stable value before the stable value is updated (5 ms at 50 MHz); must be >= 1.
- STEP_CYCLES, 50000000, clocks per sweep code step (1 s at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sw  input  3  raw asynchronous switches; sw[0]->X, sw[1]->Y, sw[2]->Z.
- sweep_en  input  1  raw asynchronous mode switch; 1 = sweep mode.
- X  output  1  conditioned X to the logic block.
- Y  output  1  conditioned Y.
- Z  output  1  conditioned Z.
- change_p  output  1  one-cycle pulse whenever {Z,Y,X} changes.

Behaviour:
- Reset (rst_n=0, asynchronous): clear all synchronizer flops, stable values, debounce counters, prescaler and sweep code. X=Y=Z=0, change_p=0, mode=SW.
- Synchronizer: every sw bit and sweep_en passes through a 2-flop synchronizer.
  - Edge 1: sync1 captures the new level.
  - Edge 2: sync2 captures it.
- Debounce, per channel, independent 2-state FSM:
  - IDLE: sync2==stable, counter held at 0. When sync2!=stable, go to COUNT with counter=1.
  - COUNT: each edge with sync2!=stable increments the counter. When the counter reaches DEBOUNCE_CYCLES, stable<=sync2, counter<=0, return to IDLE. Any edge with sync2==stable returns to IDLE with counter=0; a glitch shorter than DEBOUNCE_CYCLES is rejected.
  - Latency for a clean step: stable updates on rising edge DEBOUNCE_CYCLES+2, counting the first capturing edge as 1.
  - Counter width: clog2(DEBOUNCE_CYCLES+1); no wrap is possible.
- Mode FSM, states SW and SWEEP, driven by synchronized sweep_en (not debounced):
  - SW -> SWEEP on synchronized 1: sweep code<=0, prescaler<=0.
  - SWEEP -> SW on synchronized 0.
  - Debouncers keep running in both modes.
- Sweep, in SWEEP only:
  - The prescaler counts 0..STEP_CYCLES-1.
  - On the edge where the prescaler equals STEP_CYCLES-1, the prescaler<=0 and code<=code+1 (3-bit, 7 wraps to 0).
  - Output mapping: X=code[0], Y=code[1], Z=code[2].
- Output select:
  - SW mode: {Z,Y,X}=debounced stable values.
  - SWEEP mode: {Z,Y,X}=code.
  - Outputs are registered and switch on the same edge as the mode transition.
- change_p:
  - Registered; high for exactly the one cycle in which the new {Z,Y,X} is first visible, i.e. when the next-output value differs from the current output.
  - A mode switch that changes the output value also pulses it.
  - Simultaneous channel updates produce a single pulse.
- Reset mid-operation: immediate return to reset values. A pending debounce count is discarded, and the sweep restarts from 000 on the next entry.

Optional Feature:
- Macro: INPUT_CONDITIONER_SWEEP_EN.
- Defined: sweep mode, prescaler and mode FSM exist as above.
- Undefined: no sweep logic is built. sweep_en is ignored (its synchronizer is also removed), and outputs always follow the debounced switches.
- Port list is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=3, macro defined):
- Reset: hold rst_n=0 with sw=3'b111 -> X=Y=Z=0, change_p=0. Release rst_n, sw held at 111 -> {Z,Y,X}=111 on edge 6 after release, with change_p high for that cycle only.
- Clean step: sw 000->001 between edges -> X=1 on the 6th rising edge. Y and Z stay 0. Exactly one change_p pulse.
- Glitch reject: sw[1] high for 3 clocks, then low -> Y never changes, no change_p pulse. A further 5-clock pulse -> Y rises on its 6th edge and falls 6 edges after the release.
- Sweep: sweep_en=1 from SW with outputs 101 -> edge 2: outputs 000 with change_p. Then the code steps every 3 clocks 001,010,...,111,000 with one change_p per step.
- Mode exit: in sweep at code 011, sweep_en=0 with switches debounced at 011 -> outputs stay 011, no change_p. Repeat at code 100 -> outputs return to 011 on the synchronized edge, one change_p.
- Macro undefined: sweep_en toggled -> outputs track only the debounced switches.
